// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract. Each stage ripples one CHUNK and registers its carry,
// with valid/ready flow control that lets bubbles collapse under backpressure.

module pipelined_add_sub_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_c,
  output logic             vld,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] part_sum,
  output logic             carry
);
  logic [CHUNK-1:0] part;
  logic             c_n;
  logic [WIDTH-1:0] sum_n;

  assign {c_n, part} = {1'b0, prev_a[IDX*CHUNK +: CHUNK]}
                     + {1'b0, prev_b[IDX*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, prev_c};

  always_comb begin
    sum_n = prev_sum;
    sum_n[IDX*CHUNK +: CHUNK] = part;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld      <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      part_sum <= '0;
      carry    <= 1'b0;
    end else if (adv) begin
      vld <= prev_vld;
      // Payload only moves with a valid entry so a drained slot keeps its last result.
      if (prev_vld) begin
        op_a     <= prev_a;
        op_b     <= prev_b;
        part_sum <= sum_n;
        carry    <= c_n;
      end
    end
  end
endmodule

module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][WIDTH-1:0] a_pipe;
  logic [STAGES:0][WIDTH-1:0] b_pipe;
  logic [STAGES:0][WIDTH-1:0] s_pipe;
  logic [STAGES:0]            c_pipe;
  logic                       unused_ops;

  // Slot 0 is the operand side; subtract becomes A + ~B + 1 here.
  assign vld_pipe[0] = in_valid;
  assign a_pipe[0]   = a;
  assign b_pipe[0]   = sub ? ~b : b;
  assign s_pipe[0]   = '0;
  assign c_pipe[0]   = sub | cin;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign rdy[k] = !vld_pipe[k+1] || rdy[k+1];

    pipelined_add_sub_stage #(.WIDTH(WIDTH), .CHUNK(CHUNK), .IDX(k)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (rdy[k]),
      .prev_vld (vld_pipe[k]),
      .prev_a   (a_pipe[k]),
      .prev_b   (b_pipe[k]),
      .prev_sum (s_pipe[k]),
      .prev_c   (c_pipe[k]),
      .vld      (vld_pipe[k+1]),
      .op_a     (a_pipe[k+1]),
      .op_b     (b_pipe[k+1]),
      .part_sum (s_pipe[k+1]),
      .carry    (c_pipe[k+1])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = s_pipe[STAGES];
  assign cout      = c_pipe[STAGES];
  assign ovf       = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1])
                  && (s_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);

  // Only the sign bits of the fully-consumed operands matter past the last chunk.
  assign unused_ops = ^{a_pipe[STAGES][WIDTH-2:0], b_pipe[STAGES][WIDTH-2:0]};
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: directed flags, backpressure, reset mid-flight.

module tb_pipelined_add_sub;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic [W+1:0] v;   // {ovf, cout, sum}
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int           nchk = 0;
  int           nerr = 0;
  int           cyc = 0;
  int           pc = 0;
  int           mode = 0;
  bit           exact = 1'b0;
  bit           chk_rdy = 1'b0;
  bit           accepted = 1'b0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] h_sum;
  logic [1:0]   h_flags;
  logic [W+1:0] cur_exp;
  exp_t         q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W:0] s;
    logic       c;
    int         r;
    if (sb) begin
      s = {1'b0, x} - {1'b0, y};
      c = (x >= y);
      r = int'($signed(x)) - int'($signed(y));
    end else begin
      s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      c = s[W];
      r = int'($signed(x)) + int'($signed(y)) + int'(ci);
    end
    return {(r > (2**(W-1)) - 1) || (r < -(2**(W-1))), c, s[W-1:0]};
  endfunction

  // One clock: set out_ready, sample handshakes just after the falling edge, then advance.
  task automatic cycle();
    exp_t e;
    case (mode)
      1:       out_ready = !(pc >= 3 && pc <= 9);
      2:       out_ready = (pc % 2 == 0);
      default: out_ready = 1'b1;
    endcase
    #1;
    if (chk_rdy) chk("in_ready", in_ready, (q.size() < S) || out_ready);
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, h_sum);
      chk("hold_flags", {cout, ovf}, h_flags);
    end
    if (out_valid && q.size() == 0) chk("spurious_out", out_valid, 0);
    else if (out_valid && out_ready) begin
      e = q.pop_front();
      chk("sum", sum, e.v[W-1:0]);
      chk("cout", cout, e.v[W]);
      chk("ovf", ovf, e.v[W+1]);
      if (exact) chk("latency", cyc - e.acc, S);
    end
    hold_prev = out_valid && !out_ready;
    h_sum     = sum;
    h_flags   = {cout, ovf};
    accepted  = in_valid && in_ready;
    if (accepted) q.push_back('{v: cur_exp, acc: cyc});
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pc++;
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb, input logic [W+1:0] ex);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; cur_exp = ex;
    for (int n = 0; n < 100; n++) begin
      cycle();
      if (accepted) return;
    end
    chk("accept_timeout", accepted, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) cycle();
    chk("drain_empty", q.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic send_rand();
    logic [31:0] r;
    logic [W-1:0] x, y;
    logic ci, sb;
    r = $urandom; x = r[W-1:0];
    r = $urandom; y = r[W-1:0]; ci = r[20]; sb = r[21];
    send(x, y, ci, sb, model(x, y, ci, sb));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // Directed vectors, back-to-back at full rate
    mode = 0; exact = 1'b1; chk_rdy = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
    send(16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    drain();

    // Backpressure: stall window while streaming
    exact = 1'b0; mode = 1; pc = 0;
    for (int i = 0; i < 8; i++) send_rand();
    drain();

    // Backpressure: out_ready toggles every cycle
    mode = 2; pc = 0;
    for (int i = 0; i < 8; i++) send_rand();
    drain();

    // Reset mid-flight
    mode = 0; exact = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
    send(16'h3333, 16'h0101, 1'b1, 1'b0, model(16'h3333, 16'h0101, 1'b1, 1'b0));
    a = 16'h5555; b = 16'h0001; sub = 1'b1;
    #1 rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_flags", {cout, ovf}, 0);
    q.delete();
    hold_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) cycle();
    send(16'h0001, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0002});
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
